// File: rtl/gobou_ctrl_pipe_pkg.sv
// rtl/gobou_ctrl_pipe_pkg.sv - shared types, latency defaults and weight-select decode for gobou_ctrl_pipe
package gobou_ctrl_pipe_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_BIAS,
        S_DRAIN,
        S_SER,
        S_OUT,
        S_NEXT,
        S_DONE
    } state_e;

    localparam int MAC_LAT_DEF  = 2;
    localparam int BIAS_LAT_DEF = 1;
    localparam int RELU_LAT_DEF = 1;

    localparam int SEL_W    = 9;
    localparam int CORE_MAX = 256;

    // sel=0 selects no core; sel=k selects core k-1
    function automatic logic [CORE_MAX-1:0] onehot_dec(input logic [SEL_W-1:0] sel);
        logic [CORE_MAX-1:0] res;
        res = '0;
        if (sel != '0) begin
            res = CORE_MAX'(1) << (sel - SEL_W'(1));
        end
        return res;
    endfunction

endpackage

// File: rtl/gobou_ctrl_pipe_if.sv
// rtl/gobou_ctrl_pipe_if.sv - image/weight memory bus between the controller and the memories
interface gobou_ctrl_pipe_if #(
    parameter int DWIDTH  = 16,
    parameter int IMGSIZE = 12,
    parameter int NETSIZE = 14,
    parameter int CORE    = 16
);
    logic               mem_img_we;
    logic [IMGSIZE-1:0] mem_img_addr;
    logic [DWIDTH-1:0]  write_mem_img;
    logic [CORE-1:0]    mem_net_we;
    logic [NETSIZE-1:0] mem_net_addr;
    logic [DWIDTH-1:0]  write_result;

    modport master (
        output mem_img_we, mem_img_addr, write_mem_img, mem_net_we, mem_net_addr,
        input  write_result
    );

    modport slave (
        input  mem_img_we, mem_img_addr, write_mem_img, mem_net_we, mem_net_addr,
        output write_result
    );
endinterface

// File: rtl/gobou_ctrl_delay.sv
// rtl/gobou_ctrl_delay.sv - LAT-deep token shift register for one pipeline stage
module gobou_ctrl_delay #(
    parameter int W   = 3,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         xrst,
    input  logic [W-1:0] in_tok,
    output logic [W-1:0] out_tok
);

    generate
        if (LAT == 0) begin : g_pass
            assign out_tok = in_tok;
        end else begin : g_sr
            logic [W-1:0] sr_q [LAT];
            logic [W-1:0] sr_d [LAT];

            always_comb begin
                sr_d[0] = in_tok;
                for (int k = 1; k < LAT; k++) begin
                    sr_d[k] = sr_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (!xrst) begin
                    for (int k = 0; k < LAT; k++) begin
                        sr_q[k] <= '0;
                    end
                end else begin
                    sr_q <= sr_d;
                end
            end

            assign out_tok = sr_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/gobou_ctrl_pipe.sv
// rtl/gobou_ctrl_pipe.sv - gobou FC engine controller; GOBOU_CTRL_PIPE_PERF_EN adds perf_cycles
module gobou_ctrl_pipe
    import gobou_ctrl_pipe_pkg::*;
#(
    parameter int DWIDTH   = 16,
    parameter int IMGSIZE  = 12,
    parameter int NETSIZE  = 14,
    parameter int LWIDTH   = 10,
    parameter int CORE     = 16,
    parameter int CORELOG  = 4,
    parameter int MAC_LAT  = MAC_LAT_DEF,
    parameter int BIAS_LAT = BIAS_LAT_DEF,
    parameter int RELU_LAT = RELU_LAT_DEF
) (
    input  logic               clk,
    input  logic               xrst,
    input  logic               req,
    output logic               ack,
    input  logic               relu_en,
    input  logic               img_we,
    input  logic [IMGSIZE-1:0] input_addr,
    input  logic [IMGSIZE-1:0] output_addr,
    input  logic [DWIDTH-1:0]  write_img,
    input  logic [CORELOG:0]   net_we,
    input  logic [NETSIZE-1:0] net_addr,
    input  logic [LWIDTH-1:0]  total_in,
    input  logic [LWIDTH-1:0]  total_out,
    gobou_ctrl_pipe_if.master  mem,
    output logic               breg_we,
    output logic               serial_we,
    output logic               accum_rst,
    output logic               accum_we,
    output logic               mac_oe,
    output logic               bias_oe,
    output logic               relu_oe
`ifdef GOBOU_CTRL_PIPE_PERF_EN
    ,
    output logic [31:0]        perf_cycles
`endif
);

    state_e             state_q, state_d;
    logic               ack_q, ack_d;
    logic               relu_en_q, relu_en_d;
    logic               breg_we_q, breg_we_d;
    logic [LWIDTH-1:0]  ti_q, ti_d;
    logic [LWIDTH-1:0]  rem_q, rem_d;
    logic [LWIDTH-1:0]  i_q, i_d;
    logic [CORELOG-1:0] j_q, j_d;
    logic [IMGSIZE-1:0] in_base_q, in_base_d;
    logic [IMGSIZE-1:0] out_addr_q, out_addr_d;
    logic [NETSIZE-1:0] net_addr_q, net_addr_d;

    logic [2:0] core_tok;
    logic [2:0] mac_tok;
    logic       relu_raw;
    logic       last_i;

    assign last_i = (i_q == ti_q - LWIDTH'(1));

    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        relu_en_d  = relu_en_q;
        ti_d       = ti_q;
        rem_d      = rem_q;
        i_d        = i_q;
        j_d        = j_q;
        in_base_d  = in_base_q;
        out_addr_d = out_addr_q;
        net_addr_d = net_addr_q;
        breg_we_d  = (state_q == S_BIAS);
        core_tok   = 3'b000;
        serial_we  = 1'b0;

        mem.mem_img_we    = 1'b0;
        mem.mem_img_addr  = '0;
        mem.write_mem_img = '0;
        mem.mem_net_we    = '0;
        mem.mem_net_addr  = '0;

        case (state_q)
            S_IDLE: begin
                mem.mem_img_we    = img_we;
                mem.mem_img_addr  = input_addr;
                mem.write_mem_img = write_img;
                mem.mem_net_we    = CORE'(onehot_dec(SEL_W'(net_we)));
                mem.mem_net_addr  = net_addr;
                if (req) begin
                    ack_d      = 1'b0;
                    relu_en_d  = relu_en;
                    ti_d       = total_in;
                    rem_d      = total_out;
                    in_base_d  = input_addr;
                    out_addr_d = output_addr;
                    net_addr_d = '0;
                    i_d        = '0;
                    j_d        = '0;
                    if (total_out == '0) begin
                        state_d = S_DONE;
                    end else if (total_in == '0) begin
                        state_d = S_BIAS;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                mem.mem_img_addr = in_base_q + IMGSIZE'(i_q);
                mem.mem_net_addr = net_addr_q;
                core_tok         = {i_q == '0, 1'b1, last_i};
                net_addr_d       = net_addr_q + NETSIZE'(1);
                i_d              = i_q + LWIDTH'(1);
                if (last_i) begin
                    i_d     = '0;
                    state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                // net_addr_q already sits on the bias word; the next group starts right after it
                mem.mem_net_addr = net_addr_q;
                net_addr_d       = net_addr_q + NETSIZE'(1);
                core_tok         = {ti_q == '0, 1'b0, ti_q == '0};
                state_d          = S_DRAIN;
            end
            S_DRAIN: begin
                if (relu_en_q ? relu_oe : bias_oe) begin
                    state_d = S_SER;
                end
            end
            S_SER: begin
                serial_we = 1'b1;
                j_d       = '0;
                state_d   = S_OUT;
            end
            S_OUT: begin
                mem.mem_img_we    = 1'b1;
                mem.mem_img_addr  = out_addr_q;
                mem.write_mem_img = mem.write_result;
                out_addr_d        = out_addr_q + IMGSIZE'(1);
                rem_d             = rem_q - LWIDTH'(1);
                j_d               = j_q + CORELOG'(1);
                if (rem_q == LWIDTH'(1) || j_q == CORELOG'(CORE - 1)) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (rem_q == '0) begin
                    state_d = S_DONE;
                end else if (ti_q == '0) begin
                    state_d = S_BIAS;
                end else begin
                    state_d = S_ACC;
                end
            end
            S_DONE: begin
                ack_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            state_q    <= S_IDLE;
            ack_q      <= 1'b1;
            relu_en_q  <= 1'b0;
            breg_we_q  <= 1'b0;
            ti_q       <= '0;
            rem_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            in_base_q  <= '0;
            out_addr_q <= '0;
            net_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            relu_en_q  <= relu_en_d;
            breg_we_q  <= breg_we_d;
            ti_q       <= ti_d;
            rem_q      <= rem_d;
            i_q        <= i_d;
            j_q        <= j_d;
            in_base_q  <= in_base_d;
            out_addr_q <= out_addr_d;
            net_addr_q <= net_addr_d;
        end
    end

    gobou_ctrl_delay #(.W(3), .LAT(MAC_LAT)) u_mac_dly (
        .clk    (clk),
        .xrst   (xrst),
        .in_tok (core_tok),
        .out_tok(mac_tok)
    );

    gobou_ctrl_delay #(.W(1), .LAT(BIAS_LAT)) u_bias_dly (
        .clk    (clk),
        .xrst   (xrst),
        .in_tok (mac_oe),
        .out_tok(bias_oe)
    );

    gobou_ctrl_delay #(.W(1), .LAT(RELU_LAT)) u_relu_dly (
        .clk    (clk),
        .xrst   (xrst),
        .in_tok (bias_oe),
        .out_tok(relu_raw)
    );

    assign accum_rst = mac_tok[2];
    assign accum_we  = mac_tok[1];
    assign mac_oe    = mac_tok[0];
    assign relu_oe   = relu_raw & relu_en_q;
    assign ack       = ack_q;
    assign breg_we   = breg_we_q;

`ifdef GOBOU_CTRL_PIPE_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == S_IDLE) begin
            if (req) begin
                perf_d = '0;
            end
        end else begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
